// File: rtl/cell_test_pkg.sv
// cell_test_pkg
//   Shared types and constants for the cell tester run controller.
//   state_t      : run-controller FSM state encoding
//   SIG_*_DEF    : default MISR polynomial and per-pass seed
//   SYNC_RST_VAL : reset value of the trigger synchronizer flops. It is 1 so that a
//                  trigger already high at reset cannot look like a rising edge.
//   misr_step    : one MISR shift/fold step, shared by the MISR and the top-level signature path
//   period_last  : terminal reload value of the step-period down-counter, 2**div - 1
package cell_test_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [15:0] SIG_POLY_DEF = 16'h1021;
   localparam logic [15:0] SIG_SEED_DEF = 16'hFFFF;
   localparam logic        SYNC_RST_VAL = 1'b1;

   function automatic logic [15:0] misr_step(input logic [15:0] q,
                                             input logic [15:0] din,
                                             input logic [15:0] poly);
      return {q[14:0], 1'b0} ^ (q[15] ? poly : 16'h0000) ^ din;
   endfunction

   function automatic logic [6:0] period_last(input logic [2:0] d);
      return 7'((8'd1 << d) - 8'd1);
   endfunction

endpackage

// File: rtl/cell_test_misr.sv
// cell_test_misr
//   16-bit multiple-input signature register folding one cell response per shift.
//   clk       : system clock
//   rst_n     : synchronous active-low reset, clears q
//   seed_load : load SEED (wins over shift_en)
//   shift_en  : fold din into the signature
//   din       : cell response, zero-extended to 16 bits before folding
//   q         : current signature value
module cell_test_misr
   import cell_test_pkg::*;
#(
   parameter int          DIN_W = 8,
   parameter logic [15:0] POLY  = SIG_POLY_DEF,
   parameter logic [15:0] SEED  = SIG_SEED_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_load,
   input  logic             shift_en,
   input  logic [DIN_W-1:0] din,
   output logic [15:0]      q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (seed_load) begin
         q <= SEED;
      end else if (shift_en) begin
         q <= misr_step(q, 16'(din), POLY);
      end
   end

endmodule

// File: rtl/cell_test_sequencer.sv
// cell_test_sequencer
//   Run controller for the cell tester. A synchronized trigger rising edge starts a run
//   (or aborts one in progress). A run steps stim through all 2**STIM_W values, holding
//   each for 2**div cycles, samples cell_out on the last cycle of each step and folds it
//   into a MISR. The folded value at the end of a pass becomes the signature.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   trigger   : asynchronous start/abort pin
//   mode      : 0 single pass, 1 continuous passes (latched at start)
//   div       : step period exponent (latched at start)
//   source    : cell-group select (latched at start onto cell_sel)
//   cell_out  : response of the selected cell group
//   stim      : stimulus pattern
//   cell_sel  : latched cell-group select
//   capture   : cell_out is sampled this cycle
//   busy      : run in progress
//   done      : one-cycle pulse after each completed pass
//   signature : MISR result of the last completed pass
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no run; waiting for a trigger rise
//   RUN   | stepping stim; capture when the period counter hits zero
//   DONE  | single pass finished; signature valid; behaves as IDLE
module cell_test_sequencer
   import cell_test_pkg::*;
#(
   parameter int          STIM_W   = 8,
   parameter logic [15:0] SIG_POLY = SIG_POLY_DEF,
   parameter logic [15:0] SIG_SEED = SIG_SEED_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trigger,
   input  logic              mode,
   input  logic [2:0]        div,
   input  logic [2:0]        source,
   input  logic [STIM_W-1:0] cell_out,
   output logic [STIM_W-1:0] stim,
   output logic [2:0]        cell_sel,
   output logic              capture,
   output logic              busy,
   output logic              done,
   output logic [15:0]       signature
);

   state_t      state, state_next;
   logic        trig_s1, trig_s2, trig_prev;
   logic        rise;
   logic        start, abort, end_pass;
   logic [6:0]  pc;
   logic [2:0]  div_q;
   logic        mode_q;
   logic [15:0] misr_q;
   logic [15:0] misr_next;
   logic        misr_seed;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trig_s1   <= SYNC_RST_VAL;
         trig_s2   <= SYNC_RST_VAL;
         trig_prev <= SYNC_RST_VAL;
      end else begin
         trig_s1   <= trigger;
         trig_s2   <= trig_s1;
         trig_prev <= trig_s2;
      end
   end

   assign rise = trig_s2 & ~trig_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Abort is checked before the capture terminal count so a coincident trigger
   // suppresses the capture, the signature update and the done pulse.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      abort      = 1'b0;
      capture    = 1'b0;
      end_pass   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (rise) begin
               start      = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (rise) begin
               abort      = 1'b1;
               state_next = IDLE;
            end else if (pc == '0) begin
               capture = 1'b1;
               if (&stim) begin
                  end_pass = 1'b1;
                  if (!mode_q) begin
                     state_next = DONE;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The period counter runs down from 2**div-1; zero is the capture cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stim      <= '0;
         cell_sel  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         signature <= '0;
         pc        <= '0;
         div_q     <= '0;
         mode_q    <= 1'b0;
      end else begin
         done <= end_pass;
         if (start) begin
            div_q    <= div;
            mode_q   <= mode;
            cell_sel <= source;
            stim     <= '0;
            pc       <= period_last(div);
            busy     <= 1'b1;
         end else if (abort) begin
            stim <= '0;
            busy <= 1'b0;
         end else if (capture) begin
            pc   <= period_last(div_q);
            stim <= stim + STIM_W'(1);
            if (end_pass) begin
               signature <= misr_next;
               if (!mode_q) begin
                  busy <= 1'b0;
               end
            end
         end else if (state == RUN) begin
            pc <= pc - 7'd1;
         end
      end
   end

   assign misr_next = misr_step(misr_q, 16'(cell_out), SIG_POLY);
   assign misr_seed = start | (end_pass & mode_q);

   cell_test_misr #(
      .DIN_W (STIM_W),
      .POLY  (SIG_POLY),
      .SEED  (SIG_SEED)
   ) u_misr (
      .clk       (clk),
      .rst_n     (rst_n),
      .seed_load (misr_seed),
      .shift_en  (capture),
      .din       (cell_out),
      .q         (misr_q)
   );

endmodule

// File: tb/tb_cell_test_sequencer.sv
module tb_cell_test_sequencer;

   logic        clk;
   logic        rst_n;
   logic        trigger;
   logic        mode;
   logic [2:0]  div;
   logic [2:0]  source;
   logic [7:0]  cell_out;
   logic [7:0]  stim;
   logic [2:0]  cell_sel;
   logic        capture;
   logic        busy;
   logic        done;
   logic [15:0] signature;

   int tests_run = 0;
   int tests_failed = 0;
   int pat = 0;

   cell_test_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .trigger   (trigger),
      .mode      (mode),
      .div       (div),
      .source    (source),
      .cell_out  (cell_out),
      .stim      (stim),
      .cell_sel  (cell_sel),
      .capture   (capture),
      .busy      (busy),
      .done      (done),
      .signature (signature)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // response patterns: 0 loopback, 1 loopback with bit 0 stuck low, 2 constant zero
   function automatic logic [7:0] pat_val(input int p, input logic [7:0] s);
      case (p)
         0:       return s;
         1:       return s & 8'hFE;
         default: return 8'h00;
      endcase
   endfunction

   always_comb cell_out = pat_val(pat, stim);

   function automatic logic [15:0] model_sig(input int p);
      logic [15:0] s;
      s = 16'hFFFF;
      for (int i = 0; i < 256; i++) begin
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, pat_val(p, 8'(i))};
      end
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0] div;
      logic       mode;
      logic [2:0] source;
      int         pat;
      int         busy_len;
      bit         chg;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input vec_t v);
      int cyc, busy_cnt, cap_cnt, done_cnt, order_err;
      div = v.div; mode = v.mode; source = v.source; pat = v.pat;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      check("busy_e1", busy, 0);
      tick();
      check("busy_e2", busy, 1);
      check("stim_start", stim, 0);
      cyc = 0; busy_cnt = 0; cap_cnt = 0; done_cnt = 0; order_err = 0;
      while (busy && cyc < 40000) begin
         busy_cnt++;
         if (capture) begin
            if (stim != 8'(cap_cnt)) order_err++;
            cap_cnt++;
         end
         if (done) done_cnt++;
         if (v.chg && cyc == 100) begin
            div = 3'd0; source = ~v.source; mode = 1'b1;
         end
         tick();
         cyc++;
      end
      check("busy_len", busy_cnt, v.busy_len);
      check("captures", cap_cnt, 256);
      check("capture_order", order_err, 0);
      check("done_early", done_cnt, 0);
      check("done_pulse", done, 1);
      check("signature", signature, model_sig(v.pat));
      check("cell_sel", cell_sel, v.source);
      check("stim_end", stim, 0);
      tick();
      check("done_width", done, 0);
      mode = 1'b0;
   endtask

   initial begin
      int cyc, nd, low_busy, busy_seen;
      int done_at[3];
      logic [15:0] sig_before;

      vecs[0] = '{div: 3'd0, mode: 1'b0, source: 3'd3, pat: 0, busy_len: 256,   chg: 1'b0};
      vecs[1] = '{div: 3'd7, mode: 1'b0, source: 3'd6, pat: 0, busy_len: 32768, chg: 1'b1};
      vecs[2] = '{div: 3'd0, mode: 1'b0, source: 3'd1, pat: 1, busy_len: 256,   chg: 1'b0};
      vecs[3] = '{div: 3'd2, mode: 1'b0, source: 3'd2, pat: 2, busy_len: 1024,  chg: 1'b0};
      vecs[4] = '{div: 3'd3, mode: 1'b0, source: 3'd7, pat: 0, busy_len: 2048,  chg: 1'b0};

      rst_n = 1'b0; trigger = 1'b1; mode = 1'b0; div = 3'd0; source = 3'd0;
      repeat (3) tick();
      check("rst_stim", stim, 0);
      check("rst_cell_sel", cell_sel, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_capture", capture, 0);
      check("rst_signature", signature, 0);

      // trigger held high across reset release must not start a run
      rst_n = 1'b1;
      busy_seen = 0;
      repeat (10) begin
         tick();
         if (busy || capture) busy_seen++;
      end
      check("trig_held_no_run", busy_seen, 0);
      trigger = 1'b0;
      repeat (4) tick();

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i]);
         if (vecs[i].pat == 1) check("stuck_differs", signature != model_sig(0), 1);
         repeat (3) tick();
      end

      // continuous mode: done every 256 cycles, same signature each pass, then retrigger
      div = 3'd0; mode = 1'b1; source = 3'd4; pat = 0;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      tick();
      cyc = 0; nd = 0; low_busy = 0;
      while (nd < 3 && cyc < 2000) begin
         if (!busy) low_busy++;
         if (done) begin
            done_at[nd] = cyc;
            check("cont_signature", signature, model_sig(0));
            nd++;
         end
         if (nd < 3) begin
            tick();
            cyc++;
         end
      end
      check("cont_done_count", nd, 3);
      check("cont_done_0", done_at[0], 256);
      check("cont_done_1", done_at[1], 512);
      check("cont_done_2", done_at[2], 768);
      check("cont_busy_held", low_busy, 0);
      mode = 1'b0;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      tick();
      check("retrig_busy", busy, 0);
      check("retrig_stim", stim, 0);
      check("retrig_done", done, 0);
      check("retrig_signature", signature, model_sig(0));
      repeat (3) tick();

      // trigger rise coincides with the final capture of a pass
      sig_before = signature;
      div = 3'd0; mode = 1'b0; source = 3'd2; pat = 2;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      tick();
      check("abort_busy_start", busy, 1);
      repeat (253) tick();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      check("abort_last_stim", stim, 8'hFF);
      check("abort_no_capture", capture, 0);
      tick();
      check("abort_busy", busy, 0);
      check("abort_stim", stim, 0);
      check("abort_no_done", done, 0);
      check("abort_signature", signature, sig_before);
      busy_seen = 0;
      repeat (5) begin
         tick();
         if (busy || done || capture) busy_seen++;
      end
      check("abort_idle", busy_seen, 0);

      // reset mid-run
      div = 3'd1; mode = 1'b0; source = 3'd5; pat = 0;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      repeat (20) tick();
      check("midrun_busy_pre", busy, 1);
      rst_n = 1'b0;
      tick();
      check("midrun_rst_stim", stim, 0);
      check("midrun_rst_cell_sel", cell_sel, 0);
      check("midrun_rst_busy", busy, 0);
      check("midrun_rst_capture", capture, 0);
      check("midrun_rst_signature", signature, 0);
      check("midrun_rst_done", done, 0);
      rst_n = 1'b1;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
